divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 180 ++++++++++++++++++
 tb/tb_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, n steps per division.
// Define DIVIDER_SIGNED_EN to add signed_op/overflow and two's-complement division.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module divider #(
    parameter int unsigned n = `DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
    input  logic         signed_op,
    output logic         overflow,
`endif
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);
    localparam int unsigned CW = $clog2(n) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  acc_q, acc_d;
    logic [n-1:0]  sh_q, sh_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [n:0]    trial;
    logic [n:0]    diff;
    logic          borrow;
    logic [n-1:0]  q_step, r_step;
    logic [n-1:0]  q_fin, r_fin;
    logic [n-1:0]  a_mag, b_mag;

    // Partial remainder stays below the divisor, so the (n+1)-bit difference
    // never wraps and its sign bit is the borrow.
    assign trial  = {acc_q, sh_q[n-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign borrow = diff[n];
    assign r_step = borrow ? trial[n-1:0] : diff[n-1:0];
    assign q_step = {sh_q[n-2:0], ~borrow};

`ifdef DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic ovp_q, ovp_d, ovf_q, ovf_d;
    logic a_neg, b_neg;

    assign a_neg = signed_op & dividend[n-1];
    assign b_neg = signed_op & divisor[n-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign q_fin = qneg_q ? -q_step : q_step;
    assign r_fin = rneg_q ? -r_step : r_step;
    assign overflow = ovf_q;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_step;
    assign r_fin = r_step;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovp_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovp_q   <= ovp_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovp_d   = ovp_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        acc_d   = '0;
                        sh_d    = a_mag;
                        dvs_d   = b_mag;
`ifdef DIVIDER_SIGNED_EN
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        ovp_d   = signed_op && (dividend == {1'b1, {(n-1){1'b0}}})
                                  && (divisor == '1);
`endif
                    end
                end
            end
            RUN: begin
                acc_d = r_step;
                sh_d  = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    state_d = DONE;
                    quo_d   = q_fin;
                    rem_d   = r_fin;
                    dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    ovf_d   = ovp_q;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider (n=8) against a cycle-level arithmetic model.
`timescale 1ns/1ps

module tb_divider;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [N-1:0] dividend, divisor;
    logic         sop_r;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;
`ifdef DIVIDER_SIGNED_EN
    logic         overflow;
`endif

    divider #(.n(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIVIDER_SIGNED_EN
        .signed_op   (sop_r),
        .overflow    (overflow),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {overflow, quotient, remainder}.
    function automatic logic [16:0] ref_div(input logic [7:0] dd, input logic [7:0] dv, input logic sop);
        int a, b;
        logic [7:0] q, r;
        logic o;
        if (sop) begin
            a = int'($signed(dd));
            b = int'($signed(dv));
        end else begin
            a = int'(dd);
            b = int'(dv);
        end
        q = 8'(a / b);
        r = 8'(a % b);
        o = sop && (dd == 8'h80) && (dv == 8'hFF);
        return {o, q, r};
    endfunction

    // Cycle-level model: accept in idle, results appear n edges later, done lasts one cycle.
    logic        m_busy = 0, m_done = 0, m_z = 0, m_ovf = 0;
    logic [7:0]  m_q = 0, m_r = 0;
    int          m_left = 0;
    logic [16:0] p_res = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_done <= 0; m_z <= 0; m_ovf <= 0;
            m_q <= 0; m_r <= 0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 0;
            m_busy <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1;
                m_q    <= p_res[15:8];
                m_r    <= p_res[7:0];
                m_ovf  <= p_res[16];
                m_z    <= 0;
            end
        end else if (start) begin
            m_busy <= 1;
            if (divisor == 8'h00) begin
                m_done <= 1; m_q <= 8'hFF; m_r <= dividend; m_z <= 1; m_ovf <= 0;
            end else begin
                m_left <= N;
                p_res  <= ref_div(dividend, divisor, sop_r);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("quotient", 32'(quotient), 32'(m_q));
            chk("remainder", 32'(remainder), 32'(m_r));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
`ifdef DIVIDER_SIGNED_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
        end
    end

    // Caller is just past a falling edge with the DUT idle.
    task automatic run_div(input logic [7:0] dd, input logic [7:0] dv, input logic sop, input bit hold,
                           output int lat, output logic [7:0] q, output logic [7:0] r, output logic z);
        int k;
        start = 1; dividend = dd; divisor = dv; sop_r = sop;
        @(posedge clk); #1;
        k = cyc;
        chk("accept_busy", 32'(busy), 32'd1);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!hold) start = 0;
            if (done) begin
                lat = cyc - k;
                break;
            end
        end
        chk("done_seen", 32'(lat >= 0), 32'd1);
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    int lat;
    logic [7:0] q, r;
    logic z;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1; start = 0; dividend = 0; divisor = 0; sop_r = 0;
        #1 reset_n = 0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_z", 32'(div_by_zero), 0);
        @(negedge clk);
        cmp_en = 1;
        reset_n = 1;

        // 100/7 straight out of reset
        run_div(8'd100, 8'd7, 0, 0, lat, q, r, z);
        chk("d100_lat", 32'(lat), 8);
        chk("d100_q", 32'(q), 14);
        chk("d100_r", 32'(r), 2);
        chk("d100_z", 32'(z), 0);
        @(negedge clk);
        chk("d100_idle", 32'(busy), 0);

        // divide by zero
        run_div(8'd37, 8'd0, 0, 0, lat, q, r, z);
        chk("dz_lat", 32'(lat), 0);
        chk("dz_q", 32'(q), 255);
        chk("dz_r", 32'(r), 37);
        chk("dz_z", 32'(z), 1);
        @(negedge clk);

        // back-to-back with start held high
        run_div(8'd255, 8'd1, 0, 1, lat, q, r, z);
        chk("b2b1_q", 32'(q), 255);
        chk("b2b1_r", 32'(r), 0);
        dividend = 8'd0; divisor = 8'd5;
        @(negedge clk);
        chk("b2b_gap_idle", 32'(busy), 0);
        run_div(8'd0, 8'd5, 0, 0, lat, q, r, z);
        chk("b2b2_lat", 32'(lat), 8);
        chk("b2b2_q", 32'(q), 0);
        chk("b2b2_r", 32'(r), 0);
        @(negedge clk);

        // reset mid-division
        start = 1; dividend = 8'd200; divisor = 8'd3;
        @(posedge clk); #1;
        @(negedge clk); start = 0;
        repeat (4) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_q", 32'(quotient), 0);
        chk("mid_rst_r", 32'(remainder), 0);
        @(negedge clk);
        reset_n = 1;
        run_div(8'd50, 8'd6, 0, 0, lat, q, r, z);
        chk("post_rst_lat", 32'(lat), 8);
        chk("post_rst_q", 32'(q), 8);
        chk("post_rst_r", 32'(r), 2);
        @(negedge clk);

        // start and operands disturbed while running
        start = 1; dividend = 8'd123; divisor = 8'd10;
        @(posedge clk); #1;
        lat = -1;
        begin
            int k;
            k = cyc;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i < 7) begin
                    start = 1'($urandom);
                    dividend = 8'($urandom);
                    divisor = 8'($urandom);
                end else begin
                    start = 0;
                end
                if (done) begin
                    lat = cyc - k;
                    break;
                end
            end
        end
        chk("dist_lat", 32'(lat), 8);
        chk("dist_q", 32'(quotient), 12);
        chk("dist_r", 32'(remainder), 3);
        @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
        run_div(8'hF9, 8'd2, 1, 0, lat, q, r, z);
        chk("s_m7_q", 32'(q), 32'hFD);
        chk("s_m7_r", 32'(r), 32'hFF);
        chk("s_m7_ovf", 32'(overflow), 0);
        @(negedge clk);
        run_div(8'h80, 8'hFF, 1, 0, lat, q, r, z);
        chk("s_ovf_lat", 32'(lat), 8);
        chk("s_ovf_q", 32'(q), 32'h80);
        chk("s_ovf_r", 32'(r), 0);
        chk("s_ovf_flag", 32'(overflow), 1);
        @(negedge clk);
        run_div(8'hF0, 8'd0, 1, 0, lat, q, r, z);
        chk("s_dz_q", 32'(q), 32'hFF);
        chk("s_dz_r", 32'(r), 32'hF0);
        chk("s_dz_ovf", 32'(overflow), 0);
        @(negedge clk);
`endif

        // randomized divisions
        for (int t = 0; t < 150; t++) begin
            logic [7:0] dd, dv;
            logic s;
            dd = 8'($urandom);
            dv = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) dv = 8'($urandom_range(1, 3));
            s = 0;
`ifdef DIVIDER_SIGNED_EN
            s = 1'($urandom);
            if (t % 25 == 0) begin dd = 8'h80; dv = 8'hFF; s = 1; end
`endif
            run_div(dd, dv, s, 0, lat, q, r, z);
            chk("rand_lat", 32'(lat), (dv == 8'd0) ? 32'd0 : 32'd8);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
